// File: rtl/suma_pf_ctrl.sv
// suma_pf_ctrl: multi-cycle IEEE-754 single-precision adder sequencer.
// One 25-bit adder and one-bit-per-clock shifts are reused across the
// SWAP / ALIGN / ADD / NORM steps. Denormals flush to zero and
// rounding is truncation.
module suma_pf_ctrl #(
  parameter int ALIGN_LIMIT = 25
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a_in,
  input  logic [31:0] b_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] sum_out,
  output logic        busy
);

  localparam int DW = $clog2(ALIGN_LIMIT + 1);
  localparam logic [7:0]    LIMIT_EXP = 8'(ALIGN_LIMIT);
  localparam logic [DW-1:0] LIMIT_CNT = DW'(ALIGN_LIMIT);
  localparam logic [DW-1:0] ONE_CNT   = DW'(1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SWAP  = 3'd1,
    ALIGN = 3'd2,
    ADD   = 3'd3,
    NORM  = 3'd4,
    DONE  = 3'd5
  } state_t;

  // Registered state
  state_t        state_r;
  logic [31:0]   opA_r, opB_r;
  logic          signL_r, signS_r;
  logic [7:0]    expL_r;
  logic [23:0]   mantL_r, mantS_r;
  logic [DW-1:0] dCnt_r;
  logic [24:0]   resMant_r;
  logic [7:0]    resExp_r;
  logic [31:0]   sumOut_r;
  logic          outValid_r, inReady_r, busy_r;

  // Next-state values
  state_t        stateNxt_s;
  logic [31:0]   opANxt_s, opBNxt_s;
  logic          signLNxt_s, signSNxt_s;
  logic [7:0]    expLNxt_s;
  logic [23:0]   mantLNxt_s, mantSNxt_s;
  logic [DW-1:0] dCntNxt_s;
  logic [24:0]   resMantNxt_s;
  logic [7:0]    resExpNxt_s;
  logic [31:0]   sumOutNxt_s;
  logic          outValidNxt_s;

  // Operand decode: exponent 0 means zero (no hidden bit)
  logic [7:0]  expA_s, expB_s;
  logic [23:0] mantA_s, mantB_s;
  logic        aFirst_s;
  logic [7:0]  expDiff_s;
  logic [24:0] addRes_s;
  logic [7:0]  expInc_s, expDec_s;
  logic        inSpecial_s;

  assign expA_s    = opA_r[30:23];
  assign expB_s    = opB_r[30:23];
  assign mantA_s   = (expA_s == 8'd0) ? 24'd0 : {1'b1, opA_r[22:0]};
  assign mantB_s   = (expB_s == 8'd0) ? 24'd0 : {1'b1, opB_r[22:0]};
  // A goes first when it has the larger exponent, or equal exponent and
  // a mantissa at least as large, so mantL >= mantS after alignment.
  assign aFirst_s  = (expA_s > expB_s) || ((expA_s == expB_s) && (mantA_s >= mantB_s));
  assign expDiff_s = aFirst_s ? (expA_s - expB_s) : (expB_s - expA_s);
  // Shared 25-bit adder; ordering guarantees the subtraction never wraps.
  assign addRes_s  = (signL_r == signS_r) ? ({1'b0, mantL_r} + {1'b0, mantS_r})
                                          : ({1'b0, mantL_r} - {1'b0, mantS_r});
  assign expInc_s  = resExp_r + 8'd1;
  assign expDec_s  = resExp_r - 8'd1;
  assign inSpecial_s = (a_in[30:23] == 8'hFF) || (b_in[30:23] == 8'hFF);

  // Next-state and datapath control for the sequencer
  always_comb begin
    stateNxt_s    = state_r;
    opANxt_s      = opA_r;
    opBNxt_s      = opB_r;
    signLNxt_s    = signL_r;
    signSNxt_s    = signS_r;
    expLNxt_s     = expL_r;
    mantLNxt_s    = mantL_r;
    mantSNxt_s    = mantS_r;
    dCntNxt_s     = dCnt_r;
    resMantNxt_s  = resMant_r;
    resExpNxt_s   = resExp_r;
    sumOutNxt_s   = sumOut_r;
    outValidNxt_s = outValid_r;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          opANxt_s = a_in;
          opBNxt_s = b_in;
          if (inSpecial_s) begin
            // Inf/NaN operand is passed straight through
            sumOutNxt_s   = (a_in[30:23] == 8'hFF) ? a_in : b_in;
            outValidNxt_s = 1'b1;
            stateNxt_s    = DONE;
          end else begin
            stateNxt_s = SWAP;
          end
        end else begin
          stateNxt_s = IDLE;
        end
      end
      SWAP: begin
        signLNxt_s = aFirst_s ? opA_r[31] : opB_r[31];
        signSNxt_s = aFirst_s ? opB_r[31] : opA_r[31];
        expLNxt_s  = aFirst_s ? expA_s : expB_s;
        mantLNxt_s = aFirst_s ? mantA_s : mantB_s;
        mantSNxt_s = aFirst_s ? mantB_s : mantA_s;
        if (expDiff_s > LIMIT_EXP) begin
          dCntNxt_s = LIMIT_CNT;
        end else begin
          dCntNxt_s = expDiff_s[DW-1:0];
        end
        if (expDiff_s != 8'd0) begin
          stateNxt_s = ALIGN;
        end else begin
          stateNxt_s = ADD;
        end
      end
      ALIGN: begin
        mantSNxt_s = {1'b0, mantS_r[23:1]};
        dCntNxt_s  = dCnt_r - ONE_CNT;
        if (dCnt_r == ONE_CNT) begin
          stateNxt_s = ADD;
        end else begin
          stateNxt_s = ALIGN;
        end
      end
      ADD: begin
        resMantNxt_s = addRes_s;
        resExpNxt_s  = expL_r;
        if (addRes_s == 25'd0) begin
          sumOutNxt_s   = 32'h0000_0000;
          outValidNxt_s = 1'b1;
          stateNxt_s    = DONE;
        end else if (addRes_s[24] || !addRes_s[23]) begin
          stateNxt_s = NORM;
        end else begin
          sumOutNxt_s   = {signL_r, expL_r, addRes_s[22:0]};
          outValidNxt_s = 1'b1;
          stateNxt_s    = DONE;
        end
      end
      NORM: begin
        if (resMant_r[24]) begin
          // Carry out: one right shift always normalizes
          resMantNxt_s  = {1'b0, resMant_r[24:1]};
          resExpNxt_s   = expInc_s;
          outValidNxt_s = 1'b1;
          stateNxt_s    = DONE;
          if (expInc_s == 8'hFF) begin
            sumOutNxt_s = {signL_r, 8'hFF, 23'd0};
          end else begin
            sumOutNxt_s = {signL_r, expInc_s, resMant_r[23:1]};
          end
        end else begin
          resMantNxt_s = {resMant_r[23:0], 1'b0};
          resExpNxt_s  = expDec_s;
          if (expDec_s == 8'd0) begin
            // Result would be denormal: flush to +0
            sumOutNxt_s   = 32'h0000_0000;
            outValidNxt_s = 1'b1;
            stateNxt_s    = DONE;
          end else if (resMant_r[22]) begin
            sumOutNxt_s   = {signL_r, expDec_s, resMant_r[21:0], 1'b0};
            outValidNxt_s = 1'b1;
            stateNxt_s    = DONE;
          end else begin
            stateNxt_s = NORM;
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          outValidNxt_s = 1'b0;
          stateNxt_s    = IDLE;
        end else begin
          stateNxt_s = DONE;
        end
      end
      default: begin
        outValidNxt_s = 1'b0;
        stateNxt_s    = IDLE;
      end
    endcase
  end

  // State and datapath registers; handshake outputs are registered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      opA_r      <= 32'd0;
      opB_r      <= 32'd0;
      signL_r    <= 1'b0;
      signS_r    <= 1'b0;
      expL_r     <= 8'd0;
      mantL_r    <= 24'd0;
      mantS_r    <= 24'd0;
      dCnt_r     <= '0;
      resMant_r  <= 25'd0;
      resExp_r   <= 8'd0;
      sumOut_r   <= 32'd0;
      outValid_r <= 1'b0;
      inReady_r  <= 1'b1;
      busy_r     <= 1'b0;
    end else begin
      state_r    <= stateNxt_s;
      opA_r      <= opANxt_s;
      opB_r      <= opBNxt_s;
      signL_r    <= signLNxt_s;
      signS_r    <= signSNxt_s;
      expL_r     <= expLNxt_s;
      mantL_r    <= mantLNxt_s;
      mantS_r    <= mantSNxt_s;
      dCnt_r     <= dCntNxt_s;
      resMant_r  <= resMantNxt_s;
      resExp_r   <= resExpNxt_s;
      sumOut_r   <= sumOutNxt_s;
      outValid_r <= outValidNxt_s;
      inReady_r  <= (stateNxt_s == IDLE);
      busy_r     <= (stateNxt_s != IDLE);
    end
  end

  assign in_ready  = inReady_r;
  assign out_valid = outValid_r;
  assign sum_out   = sumOut_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_suma_pf_ctrl.sv
// Self-checking bench for suma_pf_ctrl: directed vector table, hand-written
// handshake/reset sequences, and random operands against a reference model.
module tb_suma_pf_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] sum_out;
  logic        busy;

  int checks = 0;
  int errors = 0;

  suma_pf_ctrl #(.ALIGN_LIMIT(25)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a_in(a_in), .b_in(b_in), .out_valid(out_valid), .out_ready(out_ready),
    .sum_out(sum_out), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] sum;
    int          lat;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chkInt(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model from the arithmetic rules: returns result and the
  // number of edges after the accepting edge until out_valid is seen.
  function automatic void refModel(input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] r, output int lat);
    int eA, eB, mA, mB, eL, eS, mL, mS, d, sum, p, n, e, sh;
    logic sA, sB, sL, sS;
    logic [7:0]  eBits;
    logic [22:0] fBits;
    eA = int'(a[30:23]); eB = int'(b[30:23]);
    sA = a[31]; sB = b[31];
    if (eA == 255) begin r = a; lat = 0; return; end
    if (eB == 255) begin r = b; lat = 0; return; end
    mA = (eA == 0) ? 0 : (32'h0080_0000 | int'(a[22:0]));
    mB = (eB == 0) ? 0 : (32'h0080_0000 | int'(b[22:0]));
    if (eA > eB || (eA == eB && mA >= mB)) begin
      eL = eA; mL = mA; sL = sA; eS = eB; mS = mB; sS = sB;
    end else begin
      eL = eB; mL = mB; sL = sB; eS = eA; mS = mA; sS = sA;
    end
    d = eL - eS;
    if (d > 25) d = 25;
    mS = mS >> d;
    sum = (sL == sS) ? (mL + mS) : (mL - mS);
    n = 0;
    if (sum == 0) begin
      r = 32'h0;
    end else begin
      p = 0;
      for (int i = 0; i < 25; i++) if (sum[i]) p = i;
      if (p == 24) begin
        n = 1; e = eL + 1;
        if (e == 255) begin
          r = {sL, 8'hFF, 23'd0};
        end else begin
          eBits = 8'(e); fBits = 23'(sum >> 1);
          r = {sL, eBits, fBits};
        end
      end else begin
        sh = 23 - p;
        if (eL <= sh) begin
          n = eL; r = 32'h0;
        end else begin
          n = sh; e = eL - sh;
          eBits = 8'(e); fBits = 23'(sum << sh);
          r = {sL, eBits, fBits};
        end
      end
    end
    lat = 2 + d + n;
  endfunction

  // One full operation: accept, wait for result, optional stall, handshake.
  // Called and returns at #1 after a rising edge.
  task automatic runOp(input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] expSum, input int expLat,
                       input int hold, input string tag);
    int lat;
    chk({tag, " in_ready"}, {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1; a_in = a; b_in = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, " out_valid"}, {31'd0, out_valid}, 32'd1);
    chkInt({tag, " latency"}, lat, expLat);
    chk({tag, " sum_out"}, sum_out, expSum);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      chk({tag, " held sum"}, sum_out, expSum);
      chk({tag, " held valid"}, {31'd0, out_valid}, 32'd1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, " valid drop"}, {31'd0, out_valid}, 32'd0);
    chk({tag, " idle busy"}, {31'd0, busy}, 32'd0);
  endtask

  vec_t vecs[10];

  initial begin
    logic [31:0] r;
    int lat, eA, eB, sawValid;
    logic [31:0] ra, rb;

    vecs[0] = '{32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000, 3};
    vecs[1] = '{32'h4040_0000, 32'hC020_0000, 32'h3F00_0000, 4};
    vecs[2] = '{32'h3F80_0000, 32'hBF80_0000, 32'h0000_0000, 2};
    vecs[3] = '{32'h3F80_0000, 32'h3080_0000, 32'h3F80_0000, 27};
    vecs[4] = '{32'h7F80_0000, 32'h3F80_0000, 32'h7F80_0000, 0};
    vecs[5] = '{32'h7F00_0000, 32'h7F00_0000, 32'h7F80_0000, 3};
    vecs[6] = '{32'h3F80_0000, 32'h0000_0000, 32'h3F80_0000, 27};
    vecs[7] = '{32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 2};
    vecs[8] = '{32'h3F80_0000, 32'h7FC0_0000, 32'h7FC0_0000, 0};
    vecs[9] = '{32'h0080_0000, 32'h80C0_0000, 32'h0000_0000, 3};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a_in = 32'd0; b_in = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset in_ready", {31'd0, in_ready}, 32'd1);
    chk("reset out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset sum_out", sum_out, 32'd0);
    chk("reset busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed vectors
    for (int i = 0; i < 10; i++)
      runOp(vecs[i].a, vecs[i].b, vecs[i].sum, vecs[i].lat, 0, $sformatf("vec%0d", i));

    // Stall the consumer; a pending in_valid must wait until IDLE
    in_valid = 1'b1; a_in = 32'h3F80_0000; b_in = 32'h3F80_0000;
    @(posedge clk); #1;
    a_in = 32'h4040_0000; b_in = 32'h4040_0000;
    lat = 0;
    while (!out_valid && lat < 200) begin @(posedge clk); #1; lat++; end
    chkInt("stall latency", lat, 3);
    for (int h = 0; h < 5; h++) begin
      @(posedge clk); #1;
      chk("stall sum", sum_out, 32'h4000_0000);
      chk("stall in_ready", {31'd0, in_ready}, 32'd0);
      chk("stall busy", {31'd0, busy}, 32'd1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("release valid", {31'd0, out_valid}, 32'd0);
    chk("release in_ready", {31'd0, in_ready}, 32'd1);
    chk("release busy", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("next accept busy", {31'd0, busy}, 32'd1);
    lat = 0;
    while (!out_valid && lat < 200) begin @(posedge clk); #1; lat++; end
    chkInt("next latency", lat, 3);
    chk("next sum", sum_out, 32'h40C0_0000);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;

    // Reset during ALIGN of a d=20 operation
    in_valid = 1'b1; a_in = 32'h3F80_0000; b_in = 32'h3580_0000;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("pre-reset busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    chk("midrst in_ready", {31'd0, in_ready}, 32'd1);
    chk("midrst out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst busy", {31'd0, busy}, 32'd0);
    chk("midrst sum_out", sum_out, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    sawValid = 0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #1;
      if (out_valid) sawValid = 1;
    end
    chkInt("no valid after reset", sawValid, 0);
    runOp(32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000, 3, 0, "post-reset");

    // Random operands against the reference model
    for (int k = 0; k < 150; k++) begin
      eA = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 6)) : int'($urandom_range(1, 254));
      eB = eA + int'($urandom_range(0, 60)) - 30;
      if (eB < 0) eB = 0;
      if (eB > 254) eB = 254;
      case ($urandom_range(0, 15))
        0:       eA = 255;
        1:       eB = 255;
        2:       eB = 0;
        default: ;
      endcase
      ra = $urandom;
      rb = $urandom;
      ra[30:23] = 8'(eA);
      rb[30:23] = 8'(eB);
      if ($urandom_range(0, 5) == 0) rb[22:0] = ra[22:0];
      if ($urandom_range(0, 7) == 0) rb[22:10] = ra[22:10];
      refModel(ra, rb, r, lat);
      runOp(ra, rb, r, lat, int'($urandom_range(0, 3)), $sformatf("rnd%0d", k));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
